// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and types for the register file / scoreboard slice.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   word_t / reg_addr_t     : register word and register index types
//   REG_ZERO / REG_V0       : hardwired-zero register and V0 register indices
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
    localparam reg_addr_t REG_V0   = reg_addr_t'(2);

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One combinational read port: register mux, scoreboard lookup, optional
// same-cycle forwarding of the write-back value, and hardwired-zero handling.
// Ports:
//   addr      : register index to read
//   regs_flat : all registers, register i at slice i
//   busy_vec  : scoreboard bits, register i at bit i
//   wr_en/wr_addr/wr_data : current write-back, used for forwarding
//   data/busy : read value and scoreboard bit of addr
// -----------------------------------------------------------------------------
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                 addr,
    input  logic [(1<<ADDR_W)*DATA_W-1:0]     regs_flat,
    input  logic [(1<<ADDR_W)-1:0]            busy_vec,
    input  logic                              wr_en,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    output logic [DATA_W-1:0]                 data,
    output logic                              busy
);

    logic zero_hit;
    logic byp_hit;

    assign zero_hit = (ZERO_REG != 0) && (addr == ADDR_W'(REG_ZERO));
    // A write to register 0 never forwards because zero_hit overrides below.
    assign byp_hit  = (BYPASS != 0) && wr_en && (addr == wr_addr);

    always_comb begin
        data = regs_flat[int'(addr)*DATA_W +: DATA_W];
        busy = busy_vec[addr];
        if (byp_hit) begin
            // The write-back completes the outstanding load, so not busy.
            data = wr_data;
            busy = 1'b0;
        end
        if (zero_hit) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// CPU register file with NUM_RD combinational read ports, one write-back port,
// per-register busy scoreboard for outstanding loads, and a HI/LO pair.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd_addr/rd_data/rd_busy : read ports, port k at slice k
//   wr_en/wr_addr/wr_data : write-back (also clears the busy bit)
//   pend_set/pend_addr    : mark a register busy (load issued)
//   pend_dup              : 1-cycle pulse, pend_set hit an already-busy register
//   pend_cnt              : number of busy registers
//   hilo_wr/hi_wd/lo_wd   : HI/LO write, hi/lo : HI/LO registers
//   v0                    : register V0_IDX, same forwarding rule as reads
// -----------------------------------------------------------------------------
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int V0_IDX   = int'(REG_V0)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       pend_set,
    input  logic [ADDR_W-1:0]          pend_addr,
    output logic                       pend_dup,
    output logic [ADDR_W:0]            pend_cnt,
    input  logic                       hilo_wr,
    input  logic [DATA_W-1:0]          hi_wd,
    input  logic [DATA_W-1:0]          lo_wd,
    output logic [DATA_W-1:0]          hi,
    output logic [DATA_W-1:0]          lo,
    output logic [DATA_W-1:0]          v0
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]       regs_reg [DEPTH];
    logic [DEPTH*DATA_W-1:0] regs_flat;
    logic [DEPTH-1:0]        busy_reg;
    logic [DEPTH-1:0]        busy_next;
    logic [DATA_W-1:0]       hi_reg;
    logic [DATA_W-1:0]       lo_reg;
    logic                    pend_dup_reg;
    logic                    pend_dup_next;
    logic                    wr_ok;
    logic                    pend_ok;
    logic                    v0_busy_unused;

    // Register 0 is never written when hardwired, so it keeps its reset zero.
    assign wr_ok   = wr_en    && !((ZERO_REG != 0) && (wr_addr   == ADDR_W'(REG_ZERO)));
    assign pend_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == ADDR_W'(REG_ZERO)));

    always_comb begin
        busy_next = busy_reg;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        // Applied after the clear: a same-address set wins (new load outstanding).
        if (pend_ok) begin
            busy_next[pend_addr] = 1'b1;
        end
    end

    // A duplicate only counts if the register is still busy after this
    // cycle's write-back would have cleared it.
    assign pend_dup_next = pend_ok && busy_reg[pend_addr]
                           && !(wr_ok && (wr_addr == pend_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            pend_dup_reg <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_reg[wr_addr] <= wr_data;
            end
            busy_reg <= busy_next;
            if (hilo_wr) begin
                hi_reg <= hi_wd;
                lo_reg <= lo_wd;
            end
            pend_dup_reg <= pend_dup_next;
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt = pend_cnt + (ADDR_W+1)'(busy_reg[i]);
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign pend_dup = pend_dup_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign regs_flat[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end

        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            regfile_rd_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_rd_port (
                .addr      (rd_addr[gi*ADDR_W +: ADDR_W]),
                .regs_flat (regs_flat),
                .busy_vec  (busy_reg),
                .wr_en     (wr_en),
                .wr_addr   (wr_addr),
                .wr_data   (wr_data),
                .data      (rd_data[gi*DATA_W +: DATA_W]),
                .busy      (rd_busy[gi])
            );
        end
    endgenerate

    regfile_rd_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_v0_port (
        .addr      (ADDR_W'(V0_IDX)),
        .regs_flat (regs_flat),
        .busy_vec  (busy_reg),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .data      (v0),
        .busy      (v0_busy_unused)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_sb
// Drives a forwarding (BYPASS=1) and a non-forwarding (BYPASS=0) instance with
// identical stimulus and compares both against an array-based reference model.
// -----------------------------------------------------------------------------
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_b, rd_data_n;
    logic [NR-1:0]    rd_busy_b, rd_busy_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             pend_set;
    logic [AW-1:0]    pend_addr;
    logic             dup_b, dup_n;
    logic [AW:0]      cnt_b, cnt_n;
    logic             hilo_wr;
    logic [DW-1:0]    hi_wd, lo_wd;
    logic [DW-1:0]    hi_b, lo_b, hi_n, lo_n, v0_b, v0_n;

    regfile_sb #(.BYPASS(1)) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_dup(dup_b),
        .pend_cnt(cnt_b), .hilo_wr(hilo_wr), .hi_wd(hi_wd), .lo_wd(lo_wd),
        .hi(hi_b), .lo(lo_b), .v0(v0_b)
    );

    regfile_sb #(.BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .pend_dup(dup_n),
        .pend_cnt(cnt_n), .hilo_wr(hilo_wr), .hi_wd(hi_wd), .lo_wd(lo_wd),
        .hi(hi_n), .lo(lo_n), .v0(v0_n)
    );

    // Reference model: architectural state only.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];
    logic [DW-1:0] m_hi, m_lo;
    bit            m_dup;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_hi  = '0;
        m_lo  = '0;
        m_dup = 1'b0;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && wr_en && a == wr_addr) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && wr_en && a == wr_addr) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic check_all(input string ctx);
        logic [AW-1:0] ra;
        for (int k = 0; k < NR; k++) begin
            ra = rd_addr[k*AW +: AW];
            chk($sformatf("%s rd_data%0d byp r%0d", ctx, k, ra), rd_data_b[k*DW +: DW], exp_data(ra, 1'b1));
            chk($sformatf("%s rd_data%0d nobyp r%0d", ctx, k, ra), rd_data_n[k*DW +: DW], exp_data(ra, 1'b0));
            chk($sformatf("%s rd_busy%0d byp r%0d", ctx, k, ra), rd_busy_b[k], exp_busy(ra, 1'b1));
            chk($sformatf("%s rd_busy%0d nobyp r%0d", ctx, k, ra), rd_busy_n[k], exp_busy(ra, 1'b0));
        end
        chk($sformatf("%s v0 byp", ctx), v0_b, exp_data(5'd2, 1'b1));
        chk($sformatf("%s v0 nobyp", ctx), v0_n, exp_data(5'd2, 1'b0));
        chk($sformatf("%s hi", ctx), hi_b, m_hi);
        chk($sformatf("%s lo", ctx), lo_b, m_lo);
        chk($sformatf("%s hi nobyp", ctx), hi_n, m_hi);
        chk($sformatf("%s lo nobyp", ctx), lo_n, m_lo);
        chk($sformatf("%s pend_cnt", ctx), cnt_b, model_cnt());
        chk($sformatf("%s pend_cnt nobyp", ctx), cnt_n, model_cnt());
        chk($sformatf("%s pend_dup", ctx), dup_b, m_dup);
        chk($sformatf("%s pend_dup nobyp", ctx), dup_n, m_dup);
    endtask

    task automatic drive_idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pend_set = 1'b0; pend_addr = '0;
        hilo_wr = 1'b0; hi_wd = '0; lo_wd = '0;
        rd_addr = '0;
    endtask

    // One clock transaction: drive, check combinational and registered
    // outputs before the edge, then advance the model across the edge.
    task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic ps, input logic [AW-1:0] pa,
                        input logic hw, input logic [DW-1:0] hwd, input logic [DW-1:0] lwd,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        bit dup_new;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        pend_set = ps; pend_addr = pa;
        hilo_wr = hw; hi_wd = hwd; lo_wd = lwd;
        rd_addr = {ra1, ra0};
        #1;
        n_txn++;
        check_all($sformatf("txn%0d", n_txn));
        $display("txn %0d: we=%b wa=%0d wd=%h ps=%b pa=%0d hw=%b ra=%0d/%0d cnt=%0d",
                 n_txn, we, wa, wd, ps, pa, hw, ra0, ra1, model_cnt());
        @(posedge clk);
        dup_new = 1'b0;
        if (ps && pa != 0)
            dup_new = m_busy[pa] && !(we && wa == pa);
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (ps && pa != 0) m_busy[pa] = 1'b1;
        if (hw) begin
            m_hi = hwd;
            m_lo = lwd;
        end
        m_dup = dup_new;
    endtask

    task automatic async_reset(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        @(negedge clk);
        drive_idle();
        rd_addr = {ra1, ra0};
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("async_reset");
        $display("txn %0d: async reset mid-cycle", n_txn);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] wa, pa, r0, r1;
        model_clear();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Every address on both ports after reset.
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 0, 0, 0, 0, 0, 0, AW'(a), AW'(DEPTH-1-a));

        // Forwarding of r5, then visible from the array next cycle.
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);

        // Register 0 ignores writes and pend_set.
        step(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard: set r7, r9, duplicate r7, then write-back clears r7.
        step(0, 0, 0, 1, 7, 0, 0, 0, 7, 9);
        step(0, 0, 0, 1, 9, 0, 0, 0, 7, 9);
        step(0, 0, 0, 1, 7, 0, 0, 0, 7, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 9);
        step(1, 7, 32'hA5, 0, 0, 0, 0, 0, 7, 9);
        step(0, 0, 0, 0, 0, 0, 0, 0, 7, 9);

        // Same-cycle set and write to r3: data lands, busy stays set.
        step(1, 3, 32'h55, 1, 3, 0, 0, 0, 3, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 9);

        // HI/LO and v0.
        step(0, 0, 0, 0, 0, 1, 32'h1, 32'hFFFFFFFF, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2, 32'h2A, 0, 0, 0, 0, 0, 2, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 2, 3);

        // Reset dropped in the middle of a cycle with state outstanding.
        async_reset(3, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 3, 9);

        // Randomized traffic, with one more asynchronous reset mid-run.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset(AW'($urandom_range(DEPTH-1, 0)), 2);
            wa = AW'($urandom_range(DEPTH-1, 0));
            pa = ($urandom_range(3, 0) == 0) ? wa : AW'($urandom_range(DEPTH-1, 0));
            r0 = ($urandom_range(1, 0) == 0) ? wa : AW'($urandom_range(DEPTH-1, 0));
            r1 = ($urandom_range(2, 0) == 0) ? r0 : AW'($urandom_range(DEPTH-1, 0));
            step($urandom_range(1, 0) == 1, wa, $urandom,
                 $urandom_range(9, 0) < 3, pa,
                 $urandom_range(4, 0) == 0, $urandom, $urandom, r0, r1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
